// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game controller: FSM state codes and
// the widths used by the scoring path.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LOST  = 3'd4,
    ST_OVER  = 3'd5,
    ST_WIN   = 3'd6
  } state_e;

  // Popcount result width; covers block vectors of up to 63 bits.
  localparam int POPCNT_W = 6;
  localparam int SCORE_W  = 10;
  localparam int SUM_W    = 11;
  localparam int LIVES_W  = 2;
  localparam int INC_W    = 16;

  // Points are only accumulated while a ball is in (or about to be in) play.
  function automatic logic is_scoring(input state_e s);
    return (s == ST_SERVE) || (s == ST_PLAY) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/breakout_score.sv
// Score keeper: detects newly destroyed blocks from the sticky hit flags,
// counts them, and adds PTS per block with saturation at SCORE_MAX.
module breakout_score
  import breakout_pkg::*;
#(
  parameter int NBLK      = 17,
  parameter int PTS       = 5,
  parameter int SCORE_MAX = 999
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NBLK-1:0]    i_col_detected,
  input  logic               i_clear,
  input  logic               i_count_en,
  output logic [SCORE_W-1:0] o_score
);

  logic [NBLK-1:0]     col_prev;
  logic [NBLK-1:0]     new_hits;
  logic [POPCNT_W-1:0] pop;
  logic [INC_W-1:0]    inc;
  logic [SCORE_W-1:0]  score;

  // An increment larger than the cap saturates outright; otherwise an 11-bit
  // sum of two values no greater than SCORE_MAX cannot wrap before the compare.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [INC_W-1:0]   b);
    logic [SUM_W-1:0] sum;
    if (b > INC_W'(SCORE_MAX)) begin
      return SCORE_W'(SCORE_MAX);
    end
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > SUM_W'(SCORE_MAX)) begin
      return SCORE_W'(SCORE_MAX);
    end
    return sum[SCORE_W-1:0];
  endfunction

  assign new_hits = i_col_detected & ~col_prev;

  // Count the blocks that became destroyed this cycle.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NBLK; i++) begin
      pop = pop + POPCNT_W'(new_hits[i]);
    end
  end

  assign inc = INC_W'(PTS * int'(pop));

  // Track the previous hit vector every cycle and accumulate the score.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_prev <= '0;
      score    <= '0;
    end else begin
      col_prev <= i_col_detected;
      if (i_clear) begin
        score <= '0;
      end else if (i_count_en) begin
        score <= sat_add(score, inc);
      end
    end
  end

  assign o_score = score;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: serve delay, play/pause, life accounting,
// win/over detection, and the scoring sub-block.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int NBLK         = 17,
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int PTS          = 5,
  parameter int SCORE_MAX    = 999
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ani_stb,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_endgame,
  input  logic [NBLK-1:0]    i_col_detected,
  output logic               o_mode,
  output logic               o_start,
  output logic               o_animate,
  output logic [LIVES_W-1:0] o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic [2:0]         o_state,
  output logic               o_win,
  output logic               o_over
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_e             state;
  logic [CNT_W-1:0]   serve_cnt;
  logic [LIVES_W-1:0] lives;
  logic               endgame_q;
  logic               endgame_rise;
  logic               all_hit;
  logic               serve_done;
  logic               start_game;

  assign endgame_rise = i_endgame & ~endgame_q;
  assign all_hit      = &i_col_detected;
  // The serve pulse is the decode of the final serve strobe, so it can only
  // ever be high in the cycle that moves SERVE to PLAY.
  assign serve_done   = (state == ST_SERVE) && i_ani_stb && (serve_cnt == CNT_LAST);
  assign start_game   = i_start &&
                        ((state == ST_IDLE) || (state == ST_OVER) || (state == ST_WIN));

  // Main game FSM with serve counter, lives and ball-lost edge register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      serve_cnt <= '0;
      lives     <= '0;
      endgame_q <= 1'b0;
    end else begin
      endgame_q <= i_endgame;
      case (state)
        ST_IDLE, ST_OVER, ST_WIN: begin
          if (i_start) begin
            state     <= ST_SERVE;
            lives     <= LIVES_W'(LIVES);
            serve_cnt <= '0;
          end
        end
        ST_SERVE: begin
          if (i_ani_stb) begin
            if (serve_cnt == CNT_LAST) begin
              state     <= ST_PLAY;
              serve_cnt <= '0;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (all_hit) begin
            state <= ST_WIN;
          end else if (endgame_rise) begin
            state <= ST_LOST;
            lives <= lives - 1'b1;
          end else if (i_pause) begin
            state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (i_pause) begin
            state <= ST_PLAY;
          end
        end
        ST_LOST: begin
          // Lives were already decremented on entry; zero means that was the last.
          if (lives == '0) begin
            state <= ST_OVER;
          end else begin
            state     <= ST_SERVE;
            serve_cnt <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    o_mode    = (state != ST_IDLE) && (state <= ST_WIN);
    o_animate = (state == ST_PLAY);
    o_win     = (state == ST_WIN);
    o_over    = (state == ST_OVER);
  end

  assign o_start = serve_done;
  assign o_state = state;
  assign o_lives = lives;

  breakout_score #(
    .NBLK      (NBLK),
    .PTS       (PTS),
    .SCORE_MAX (SCORE_MAX)
  ) u_score (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_col_detected (i_col_detected),
    .i_clear        (start_game),
    .i_count_en     (is_scoring(state)),
    .o_score        (o_score)
  );

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl: default instance for the game flow,
// plus a small instance (4 blocks, 300 points, 1 life, 1-frame serve) for
// score saturation and single-life game over.
module tb_breakout_game_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_ani_stb;
  logic        i_start;
  logic        i_pause;
  logic        i_endgame;
  logic [16:0] i_col_detected;
  logic        o_mode;
  logic        o_start;
  logic        o_animate;
  logic [1:0]  o_lives;
  logic [9:0]  o_score;
  logic [2:0]  o_state;
  logic        o_win;
  logic        o_over;

  logic        s_rst_n;
  logic        s_stb;
  logic        s_start;
  logic        s_pause;
  logic        s_end;
  logic [3:0]  s_col;
  logic        s_mode;
  logic        s_ostart;
  logic        s_animate;
  logic [1:0]  s_lives;
  logic [9:0]  s_score;
  logic [2:0]  s_state;
  logic        s_win;
  logic        s_over;

  int n_tests = 0;
  int n_fail  = 0;

  breakout_game_ctrl u_dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_ani_stb      (i_ani_stb),
    .i_start        (i_start),
    .i_pause        (i_pause),
    .i_endgame      (i_endgame),
    .i_col_detected (i_col_detected),
    .o_mode         (o_mode),
    .o_start        (o_start),
    .o_animate      (o_animate),
    .o_lives        (o_lives),
    .o_score        (o_score),
    .o_state        (o_state),
    .o_win          (o_win),
    .o_over         (o_over)
  );

  breakout_game_ctrl #(
    .NBLK         (4),
    .LIVES        (1),
    .SERVE_FRAMES (1),
    .PTS          (300),
    .SCORE_MAX    (999)
  ) u_dut_sat (
    .i_clk          (i_clk),
    .i_rst_n        (s_rst_n),
    .i_ani_stb      (s_stb),
    .i_start        (s_start),
    .i_pause        (s_pause),
    .i_endgame      (s_end),
    .i_col_detected (s_col),
    .o_mode         (s_mode),
    .o_start        (s_ostart),
    .o_animate      (s_animate),
    .o_lives        (s_lives),
    .o_score        (s_score),
    .o_state        (s_state),
    .o_win          (s_win),
    .o_over         (s_over)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // 60 strobes separated by idle cycles; exactly one serve pulse, on the last strobe.
  task automatic do_serve(input string tag);
    int pulses;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      i_ani_stb = 1'b1;
      #1;
      if (o_start) pulses++;
      if (k == 59) chk({tag, "_start_on_60th"}, o_start, 1);
      step();
      i_ani_stb = 1'b0;
      #1;
      if (o_start) pulses++;
      if (k == 58) chk({tag, "_still_serve"}, o_state, 1);
      if (k == 59) chk({tag, "_play_next"}, o_state, 2);
      step();
    end
    chk({tag, "_pulse_count"}, pulses, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    i_rst_n = 1'b0; i_ani_stb = 1'b0; i_start = 1'b0; i_pause = 1'b0;
    i_endgame = 1'b0; i_col_detected = '0;
    s_rst_n = 1'b0; s_stb = 1'b0; s_start = 1'b0; s_pause = 1'b0;
    s_end = 1'b0; s_col = '0;
    #3;
    chk("rst_state", o_state, 0);
    chk("rst_lives", o_lives, 0);
    chk("rst_score", o_score, 0);
    chk("rst_mode", o_mode, 0);
    step(); step();
    i_rst_n = 1'b1; s_rst_n = 1'b1;
    step();
    chk("idle_state", o_state, 0);

    // Start and first serve.
    i_start = 1'b1; step(); i_start = 1'b0;
    chk("serve_state", o_state, 1);
    chk("serve_lives", o_lives, 3);
    chk("serve_mode", o_mode, 1);
    chk("serve_anim", o_animate, 0);
    do_serve("serve1");
    chk("play_lives", o_lives, 3);
    chk("play_anim", o_animate, 1);

    // Three new blocks at once, then hold.
    i_col_detected = 17'h00007; step();
    chk("score_3blk", o_score, 15);
    step();
    chk("score_hold", o_score, 15);

    // Pause: frozen ball, scoring continues, start ignored.
    i_pause = 1'b1; step(); i_pause = 1'b0;
    chk("pause_state", o_state, 3);
    chk("pause_anim", o_animate, 0);
    i_col_detected = 17'h0000F; step();
    chk("pause_score", o_score, 20);
    i_start = 1'b1; step(); i_start = 1'b0;
    chk("pause_start_ign", o_state, 3);
    i_pause = 1'b1; step(); i_pause = 1'b0;
    chk("resume_state", o_state, 2);
    chk("resume_anim", o_animate, 1);

    // First loss; level held high through re-serve must not cost a life.
    i_endgame = 1'b1; step();
    chk("lost1_state", o_state, 4);
    chk("lost1_lives", o_lives, 2);
    step();
    chk("lost1_reserve", o_state, 1);
    do_serve("serve2");
    step(); step(); step();
    chk("held_end_state", o_state, 2);
    chk("held_end_lives", o_lives, 2);

    // Second loss.
    i_endgame = 1'b0; step();
    i_endgame = 1'b1; step();
    chk("lost2_lives", o_lives, 1);
    step();
    chk("lost2_reserve", o_state, 1);
    i_endgame = 1'b0;
    do_serve("serve3");

    // Third loss -> game over, no serve pulse afterwards.
    i_endgame = 1'b1; step();
    chk("lost3_lives", o_lives, 0);
    step();
    i_endgame = 1'b0;
    chk("over_state", o_state, 5);
    chk("over_flag", o_over, 1);
    chk("over_mode", o_mode, 1);
    chk("over_anim", o_animate, 0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      i_ani_stb = 1'b1; #1;
      if (o_start) pulses++;
      step();
      i_ani_stb = 1'b0;
    end
    chk("over_no_start", pulses, 0);
    i_col_detected = 17'h0001F; step();
    chk("over_no_score", o_score, 20);
    i_col_detected = '0; step();

    // Restart from OVER reloads lives and score.
    i_start = 1'b1; step(); i_start = 1'b0;
    chk("restart_state", o_state, 1);
    chk("restart_lives", o_lives, 3);
    chk("restart_score", o_score, 0);
    chk("restart_over", o_over, 0);
    do_serve("serve4");

    // Clear the board; last block and ball loss in the same cycle -> WIN.
    i_col_detected = 17'h00007; step();
    chk("win_score15", o_score, 15);
    i_col_detected = 17'h0FFFF; step();
    chk("win_score80", o_score, 80);
    i_col_detected = 17'h1FFFF; i_endgame = 1'b1; step();
    i_endgame = 1'b0;
    chk("win_state", o_state, 6);
    chk("win_flag", o_win, 1);
    chk("win_lives", o_lives, 3);
    chk("win_score", o_score, 85);

    // New game, score 40 during SERVE, then asynchronous reset mid-cycle.
    i_col_detected = '0; step();
    i_start = 1'b1; step(); i_start = 1'b0;
    chk("win_restart", o_state, 1);
    chk("win_restart_score", o_score, 0);
    i_col_detected = 17'h000FF; step();
    chk("serve_score40", o_score, 40);
    i_ani_stb = 1'b1; step(); step(); i_ani_stb = 1'b0;
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_mode", o_mode, 0);
    chk("arst_anim", o_animate, 0);
    chk("arst_start", o_start, 0);
    chk("arst_lives", o_lives, 0);
    chk("arst_score", o_score, 0);
    chk("arst_flags", {o_win, o_over}, 0);
    i_col_detected = '0;
    step();
    i_rst_n = 1'b1;
    step();
    chk("post_rst_state", o_state, 0);

    // Saturating instance: 3 blocks -> 900, 2 more -> capped at 999.
    s_start = 1'b1; step(); s_start = 1'b0;
    chk("sat_serve", s_state, 1);
    chk("sat_lives", s_lives, 1);
    s_stb = 1'b1; #1;
    chk("sat_start_pulse", s_ostart, 1);
    step(); s_stb = 1'b0;
    chk("sat_play", s_state, 2);
    s_col = 4'b0111; step();
    chk("sat_score900", s_score, 900);
    s_col = 4'b0000; step();
    s_col = 4'b0011; step();
    chk("sat_score999", s_score, 999);
    chk("sat_still_play", s_state, 2);
    s_end = 1'b1; step();
    chk("sat_lost_lives", s_lives, 0);
    step();
    chk("sat_over", s_over, 1);
    chk("sat_over_state", s_state, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/breakout_game_ctrl.md
BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

Interface
REQ-001 Parameter NBLK, default 17, number of breakable blocks (width of block-hit vector).
REQ-002 Parameter LIVES, default 3, lives granted per game (1..3).
REQ-003 Parameter SERVE_FRAMES, default 60, animation strobes spent in SERVE before the ball is released (>=1).
REQ-004 Parameter PTS, default 5, points per newly destroyed block.
REQ-005 Parameter SCORE_MAX, default 999, score saturation value.
REQ-006 One clock; reset is asynchronous and active-low: i_clk  in  1  base clock; all state on rising edge.
REQ-007 i_rst_n  in  1  asynchronous active-low reset.
REQ-008 i_ani_stb  in  1  one-cycle frame strobe.
REQ-009 i_start  in  1  one-cycle start pulse, already debounced.
REQ-010 i_pause  in  1  one-cycle pause-toggle pulse.
REQ-011 i_endgame  in  1  ball-lost level from ball module.
REQ-012 i_col_detected  in  NBLK  sticky per-block destroyed flags from ball module.
REQ-013 o_mode  out  1  ball module enable; low forces ball to its home position.
REQ-014 o_start  out  1  one-cycle serve pulse to ball module.
REQ-015 o_animate  out  1  ball motion enable.
REQ-016 o_lives  out  2  remaining lives.
REQ-017 o_score  out  10  binary score.
REQ-018 o_state  out  3  current FSM state encoding.
REQ-019 o_win / o_over  out  1 each  level flags, high in WIN / OVER respectively.

Function
REQ-020 FSM states SHALL be IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LOST=4, OVER=5, WIN=6; unused codes return to IDLE next cycle.
REQ-021 IDLE: o_mode=0, o_animate=0; i_start -> SERVE, loading o_lives=LIVES, o_score=0, serve counter=0.
REQ-022 SERVE: o_mode=1, o_animate=0; counter increments on each i_ani_stb; on the strobe where counter reaches SERVE_FRAMES-1, assert o_start for exactly that cycle and enter PLAY next cycle.
REQ-023 PLAY: o_mode=1, o_animate=1; i_pause -> PAUSE; rising edge of i_endgame -> LOST; all NBLK bits of i_col_detected set -> WIN.
REQ-024 PLAY priority when simultaneous: WIN > LOST > PAUSE.
REQ-025 PAUSE: o_mode=1, o_animate=0; i_pause -> PLAY; i_start ignored.
REQ-026 LOST: decrement o_lives once on entry; if the pre-decrement value was 1 go to OVER (o_lives=0), else go to SERVE with counter cleared.
REQ-027 OVER and WIN: o_mode=1, o_animate=0, flag high; i_start -> IDLE-equivalent restart, i.e. directly to SERVE with lives and score reloaded.
REQ-028 Score: each cycle, new = i_col_detected & ~col_prev (col_prev registered every cycle); o_score += PTS * popcount(new), saturating at SCORE_MAX, counted in SERVE, PLAY and PAUSE only.
REQ-029 Score arithmetic SHALL use an 11-bit intermediate sum so no wrap occurs before saturation.
REQ-030 i_endgame edge detector SHALL be registered; a level held high across LOST/SERVE SHALL NOT cause a second life loss.
REQ-031 o_start SHALL never assert outside the SERVE->PLAY transition cycle.

Reset
REQ-032 Asserting i_rst_n low SHALL immediately force IDLE, o_mode=0, o_start=0, o_animate=0, o_lives=0, o_score=0, counters and edge-detect registers 0, o_win=o_over=0, including mid-game.

Structure
REQ-033 State encodings and the popcount-width constant SHALL live in shared package breakout_pkg.
REQ-034 Scoring (edge detect, popcount, saturating add) SHALL be sub-module breakout_score.

Verification
REQ-035 Reset, i_start, 60 strobes -> o_start single pulse on 60th strobe, o_state=PLAY next cycle, o_lives=3.
REQ-036 In PLAY raise i_endgame three times, each after re-serve -> o_lives 2,1,0; final state OVER, o_over=1, no o_start after third loss.
REQ-037 In PLAY set 3 new col bits in one cycle -> o_score +15; set all 17 -> WIN, o_score=85.
REQ-038 Same cycle: last block bit and i_endgame rise -> WIN, o_lives unchanged.
REQ-039 i_pause in PLAY -> o_animate=0, new block bits still score; second i_pause -> PLAY.
REQ-040 Drop i_rst_n mid-SERVE with score 40 -> all outputs zero asynchronously, state IDLE.
